timer_counter: RTL and testbench

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_counter_if.sv | 18 +
 rtl/timer_counter.sv | 63 ++++++
 tb/tb_timer_counter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/timer_counter_if.sv
// timer_counter_if: control/status bundle between the timer register block and the timer core
interface timer_counter_if;
    logic        timer_enable;
    logic        timer_one_shot;
    logic [31:0] timer_count;
    logic        timer_interrupt_clear;
    logic        timer_interrupt;
    logic [31:0] current_count;
    logic        timer_running;
    modport master (
        output timer_enable, timer_one_shot, timer_count, timer_interrupt_clear,
        input  timer_interrupt, current_count, timer_running
    );
    modport slave (
        input  timer_enable, timer_one_shot, timer_count, timer_interrupt_clear,
        output timer_interrupt, current_count, timer_running
    );
endinterface

// File: rtl/timer_counter.sv
// timer_counter: prescaled 32-bit down-counter with one-shot/periodic expiry and sticky interrupt
module timer_counter #(
    parameter int PRESCALE = 1
) (
    input logic clk,
    input logic reset,
    timer_counter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    state_t state;
    logic [PW-1:0] psc;
    logic [31:0] count;
    logic irq;
    logic running;
    logic tick;
    logic expire;
    assign tick = psc == LAST;
    assign expire = state == RUN && bus.timer_enable && tick && count == '0;
    assign bus.current_count = count;
    assign bus.timer_interrupt = irq;
    assign bus.timer_running = running;
    // state machine, counter, prescaler and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            psc <= '0;
            irq <= 1'b0;
            running <= 1'b0;
        end else begin
            irq <= expire ? 1'b1 : (bus.timer_interrupt_clear ? 1'b0 : irq);
            case (state)
                IDLE: if (bus.timer_enable) begin
                    count <= bus.timer_count;
                    psc <= '0;
                    state <= RUN;
                    running <= 1'b1;
                end
                RUN: if (!bus.timer_enable) begin
                    state <= IDLE;
                    running <= 1'b0;
                end else begin
                    psc <= tick ? '0 : psc + 1'b1;
                    if (tick && count != '0) begin
                        count <= count - 1'b1;
                    end else if (expire && bus.timer_one_shot) begin
                        state <= DONE;
                        running <= 1'b0;
                    end else if (expire) begin
                        count <= bus.timer_count;
                    end
                end
                DONE: if (!bus.timer_enable) state <= IDLE;
                default: begin
                    state <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: scoreboard bench comparing two prescale variants against a cycle-count model
module tb_timer_counter;
    typedef struct {
        logic [31:0] cur;
        bit irq;
        bit run;
    } exp_t;
    logic clk = 0;
    logic reset = 1;
    timer_counter_if bus1();
    timer_counter_if bus4();
    timer_counter #(.PRESCALE(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    timer_counter #(.PRESCALE(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
    always #5 clk = ~clk;
    exp_t q1[$];
    exp_t q4[$];
    int checks = 0;
    int errors = 0;
    int pres[2] = '{1, 4};
    int mode[2];
    longint n[2];
    longint k[2];
    logic [31:0] cur[2];
    bit irq[2];
    bit done_stim = 0;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask
    task automatic model(input int i, input bit r, input bit en, input bit os,
                         input logic [31:0] c, input bit clr);
        bit ex;
        ex = 0;
        if (r) begin
            mode[i] = 0;
            cur[i] = 0;
            irq[i] = 0;
            return;
        end
        if (mode[i] == 0) begin
            if (en) begin
                n[i] = c;
                k[i] = 0;
                cur[i] = c;
                mode[i] = 1;
            end
        end else if (mode[i] == 1) begin
            if (!en) mode[i] = 0;
            else begin
                k[i]++;
                if (k[i] == (n[i] + 1) * pres[i]) begin
                    ex = 1;
                    if (os) begin
                        mode[i] = 2;
                        cur[i] = 0;
                    end else begin
                        n[i] = c;
                        k[i] = 0;
                        cur[i] = c;
                    end
                end else cur[i] = 32'(n[i] - k[i] / pres[i]);
            end
        end else if (!en) mode[i] = 0;
        irq[i] = ex ? 1'b1 : (clr ? 1'b0 : irq[i]);
    endtask
    task automatic step(input bit r, input bit en, input bit os, input logic [31:0] c, input bit clr);
        exp_t e;
        @(negedge clk);
        reset = r;
        bus1.timer_enable = en;
        bus4.timer_enable = en;
        bus1.timer_one_shot = os;
        bus4.timer_one_shot = os;
        bus1.timer_count = c;
        bus4.timer_count = c;
        bus1.timer_interrupt_clear = clr;
        bus4.timer_interrupt_clear = clr;
        for (int i = 0; i < 2; i++) begin
            model(i, r, en, os, c, clr);
            e.cur = cur[i];
            e.irq = irq[i];
            e.run = mode[i] == 1;
            if (i == 0) q1.push_back(e);
            else q4.push_back(e);
        end
    endtask
    // monitor: pop the expected response for each edge and compare both variants
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("p1_count", bus1.current_count, e.cur);
            chk("p1_irq", 32'(bus1.timer_interrupt), 32'(e.irq));
            chk("p1_running", 32'(bus1.timer_running), 32'(e.run));
        end
        if (q4.size() > 0) begin
            e = q4.pop_front();
            chk("p4_count", bus4.current_count, e.cur);
            chk("p4_irq", 32'(bus4.timer_interrupt), 32'(e.irq));
            chk("p4_running", 32'(bus4.timer_running), 32'(e.run));
        end
    end
    // stimulus: directed scenarios followed by randomized traffic
    initial begin
        bit r;
        bit en;
        bit os;
        bit clr;
        logic [31:0] c;
        repeat (2) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 1, 3, 0);
        step(0, 0, 1, 3, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 2, i % 3 == 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 2, 1);
        step(0, 0, 0, 2, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 10, 0);
        step(0, 0, 0, 10, 0);
        step(0, 0, 0, 10, 0);
        step(0, 1, 0, 10, 0);
        step(0, 1, 0, 10, 0);
        step(0, 0, 1, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 149) == 0;
            en = $urandom_range(0, 11) != 0;
            os = $urandom_range(0, 3) == 0;
            c = $urandom_range(0, 19) == 0 ? $urandom : 32'($urandom_range(0, 6));
            clr = $urandom_range(0, 5) == 0;
            step(r, en, os, c, clr);
        end
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(q1.size() + q4.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
